request_unit: RTL and testbench

// - Memory-side counterpart of the control unit: consumes decoded dREN/dWEN/halt and returns pcEn.
// - Sequences each instruction: fetch (imemREN until ihit), then an optional data access (dmemREN/dmemWEN until dhit).
// - Sits between control_unit and the cache/memory arbiter. Holds data requests stable until serviced.
// - Gates PC advance so every instruction retires exactly once.

---
 rtl/request_unit.sv | 137 +++++++++++++
 tb/tb_request_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/request_unit.sv
// ============================================================================
// Module   : request_unit
// Purpose  : Sequences instruction fetch and optional data access, and gates
//            the PC-advance strobe so that each instruction retires once.
// Options  : REQ_TIMEOUT_EN enables the data-request timeout (req_err).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module request_unit #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic CLK,
  input  logic nRST,
  input  logic ihit,
  input  logic dhit,
  input  logic cu_dREN,
  input  logic cu_dWEN,
  input  logic cu_halt,
  output logic imemREN,
  output logic dmemREN,
  output logic dmemWEN,
  output logic pcEn,
  output logic halt,
  output logic req_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DLOAD  = 2'd1,
    DSTORE = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  if (TIMEOUT_CYC >= (1 << CNT_W)) begin : g_cfg_check
    $error("request_unit: TIMEOUT_CYC must be below 2**CNT_W");
  end

  // Async clear drops any held data request without waiting for a clock.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    imemREN    = 1'b0;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    pcEn       = 1'b0;
    halt       = 1'b0;
    case (state)
      IDLE: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (cu_halt) begin
            next_state = HALTED;
          end else if (cu_dWEN) begin
            next_state = DSTORE;
          end else if (cu_dREN) begin
            next_state = DLOAD;
          end else begin
            pcEn = 1'b1;
          end
        end
      end
      DLOAD: begin
        dmemREN = 1'b1;
        if (dhit) begin
          pcEn       = 1'b1;
          next_state = IDLE;
        end
      end
      DSTORE: begin
        dmemWEN = 1'b1;
        if (dhit) begin
          pcEn       = 1'b1;
          next_state = IDLE;
        end
      end
      HALTED: begin
        halt = 1'b1;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

`ifdef REQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             err_q;
  logic             busy;

  assign busy = (state == DLOAD) || (state == DSTORE);

  always_comb begin
    cnt_next = wait_cnt;
    if ((state == IDLE) && ((next_state == DLOAD) || (next_state == DSTORE))) begin
      cnt_next = '0;
    end else if (busy && !dhit && (wait_cnt != CNT_MAX)) begin
      cnt_next = wait_cnt + 1'b1;
    end
  end

  // Error flags on the same edge the count reaches the limit; request keeps waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= cnt_next;
      if (busy && (cnt_next >= TIMEOUT_VAL)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign req_err = err_q;
`else
  assign req_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_request_unit.sv
// Directed vector table plus hand-written multi-cycle sequences for request_unit.
`default_nettype none

module tb_request_unit;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, cu_dREN, cu_dWEN, cu_halt;
  logic imemREN, dmemREN, dmemWEN, pcEn, halt, req_err;

  int checks = 0;
  int errors = 0;

  request_unit #(
    .TIMEOUT_CYC(8),
    .CNT_W      (8)
  ) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .ihit   (ihit),
    .dhit   (dhit),
    .cu_dREN(cu_dREN),
    .cu_dWEN(cu_dWEN),
    .cu_halt(cu_halt),
    .imemREN(imemREN),
    .dmemREN(dmemREN),
    .dmemWEN(dmemWEN),
    .pcEn   (pcEn),
    .halt   (halt),
    .req_err(req_err)
  );

  always #5 CLK = ~CLK;

  // Output bundle order: {imemREN, dmemREN, dmemWEN, pcEn, halt, req_err}
  typedef struct {
    string      name;
    logic       ihit;
    logic       dhit;
    logic       dren;
    logic       dwen;
    logic       hlt;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [5:0] outs();
    return {imemREN, dmemREN, dmemWEN, pcEn, halt, req_err};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Apply inputs at the falling edge and settle before sampling.
  task automatic drive(input logic i, input logic d, input logic r, input logic w, input logic h);
    @(negedge CLK);
    ihit = i; dhit = d; cu_dREN = r; cu_dWEN = w; cu_halt = h;
    #1;
  endtask

  initial begin
    int n;
    nRST = 1'b0; ihit = 0; dhit = 0; cu_dREN = 0; cu_dWEN = 0; cu_halt = 0;

    vecs[0]  = '{"idle_nohit",   0, 0, 0, 0, 0, 6'b100000};
    vecs[1]  = '{"alu_1",        1, 0, 0, 0, 0, 6'b100100};
    vecs[2]  = '{"alu_2",        1, 0, 0, 0, 0, 6'b100100};
    vecs[3]  = '{"load_issue",   1, 0, 1, 0, 0, 6'b100000};
    vecs[4]  = '{"load_wait",    0, 0, 0, 0, 0, 6'b010000};
    vecs[5]  = '{"load_ihit",    1, 0, 0, 0, 0, 6'b010000};
    vecs[6]  = '{"load_dhit",    0, 1, 0, 0, 0, 6'b010100};
    vecs[7]  = '{"after_load",   0, 0, 0, 0, 0, 6'b100000};
    vecs[8]  = '{"store_both",   1, 0, 1, 1, 0, 6'b100000};
    vecs[9]  = '{"store_idhit",  1, 1, 0, 0, 0, 6'b001100};
    vecs[10] = '{"idle_dhit",    0, 1, 0, 0, 0, 6'b100000};
    vecs[11] = '{"alu_3",        1, 0, 0, 0, 0, 6'b100100};

    #2;
    check("reset_outs", 32'(outs()), 32'b100000);
    @(negedge CLK);
    nRST = 1'b1;

    for (int k = 0; k < 12; k++) begin
      drive(vecs[k].ihit, vecs[k].dhit, vecs[k].dren, vecs[k].dwen, vecs[k].hlt);
      check(vecs[k].name, 32'(outs()), 32'(vecs[k].exp));
    end

    // Ten back-to-back ALU fetches.
    n = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 0, 0, 0);
      if (pcEn) n++;
    end
    check("alu_pulses", 32'(n), 32'd10);

    // Load with three wait cycles.
    drive(1, 0, 1, 0, 0);
    check("ld_issue_pc", 32'(pcEn), 32'd0);
    drive(0, 0, 0, 0, 0);
    check("ld_req", 32'(outs()), 32'b010000);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("ld_wait3", 32'(outs()), 32'b010000);
    drive(0, 1, 0, 0, 0);
    check("ld_dhit", 32'(outs()), 32'b010100);
    drive(0, 0, 0, 0, 0);
    check("ld_done", 32'(outs()), 32'b100000);

    // Store where dhit and a stray ihit coincide: exactly one pcEn.
    drive(1, 0, 1, 1, 0);
    n = pcEn ? 1 : 0;
    drive(0, 0, 0, 0, 0);
    check("st_only_wen", 32'(outs()), 32'b001000);
    drive(1, 1, 0, 0, 0);
    if (pcEn) n++;
    drive(0, 0, 0, 0, 0);
    if (pcEn) n++;
    check("st_one_pc", 32'(n), 32'd1);

    // Halt beats a simultaneous store; stays halted under input noise.
    drive(1, 0, 0, 1, 1);
    check("halt_issue", 32'(outs()), 32'b100000);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if (outs() !== 6'b000010) n++;
    end
    check("halt_held_bad", 32'(n), 32'd0);

    // Reset leaves HALTED.
    @(negedge CLK);
    ihit = 0; dhit = 0; cu_dREN = 0; cu_dWEN = 0; cu_halt = 0;
    nRST = 1'b0;
    #1;
    check("halt_reset", 32'(outs()), 32'b100000);
    @(negedge CLK);
    nRST = 1'b1;

    // Reset mid-load drops dmemREN without a clock edge.
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("midld_req", 32'(dmemREN), 32'd1);
    nRST = 1'b0;
    #1;
    check("midld_async", 32'(dmemREN), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("midld_after", 32'(outs()), 32'b100000);

`ifdef REQ_TIMEOUT_EN
    drive(1, 0, 1, 0, 0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 0, 0, 0);
      if (req_err) break;
      n++;
    end
    check("to_cycles", 32'(n), 32'd8);
    check("to_outs", 32'(outs()), 32'b010001);
    drive(0, 1, 0, 0, 0);
    check("to_dhit_pc", 32'(pcEn), 32'd1);
    drive(0, 0, 0, 0, 0);
    check("to_sticky", 32'(outs()), 32'b100001);
`else
    drive(0, 0, 0, 0, 0);
    check("req_err_tied", 32'(req_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
